// File: rtl/garbage_manager_pkg.sv
// Shared constants, FSM state types and the hole-column helper for the
// garbage manager (attack cancellation, transmit and playfield insertion).
package garbage_manager_pkg;

    localparam int PLAYFIELD_COLS    = 10;
    localparam int GARBAGE_CNT_WIDTH = 10;
    localparam int MAX_PENDING       = 20;
    localparam int MAX_INSERT        = 8;
    localparam int TX_MAX            = 31;
    localparam int LINE_CNT_WIDTH    = 5;
    localparam int HOLE_COL_WIDTH    = 4;
    localparam int LFSR_WIDTH        = 16;

    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic {
        INS_IDLE = 1'b0,
        INS_REQ  = 1'b1
    } ins_state_t;

    // Fold a 4-bit random nibble onto the playfield columns; 10..15 wrap to 0..5.
    function automatic logic [HOLE_COL_WIDTH-1:0] hole_col_from_nibble(
        input logic [HOLE_COL_WIDTH-1:0] h
    );
        logic [HOLE_COL_WIDTH-1:0] cols;
        cols = HOLE_COL_WIDTH'(PLAYFIELD_COLS);
        if (h < cols) begin
            return h;
        end else begin
            return h - cols;
        end
    endfunction

endpackage

// File: rtl/garbage_manager_hole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a registered
// playfield hole column; deliberately untouched by game_start.
module garbage_hole_lfsr
    import garbage_manager_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_l,
    output logic [HOLE_COL_WIDTH-1:0] hole_col
);

    logic [LFSR_WIDTH-1:0]     lfsr_r;
    logic [LFSR_WIDTH-1:0]     lfsr_nxt_s;
    logic [HOLE_COL_WIDTH-1:0] col_r;

    // Next LFSR value: shift left, feedback from taps 16,14,13,11.
    always_comb begin
        lfsr_nxt_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end

    // LFSR state and the column derived from the state it is moving to.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lfsr_r <= LFSR_SEED;
            col_r  <= hole_col_from_nibble(LFSR_SEED[HOLE_COL_WIDTH-1:0]);
        end else begin
            lfsr_r <= lfsr_nxt_s;
            col_r  <= hole_col_from_nibble(lfsr_nxt_s[HOLE_COL_WIDTH-1:0]);
        end
    end

    assign hole_col = col_r;

endmodule

// File: rtl/garbage_manager.sv
// Garbage manager: cancels outgoing attack against pending incoming garbage,
// streams the surplus to the transmitter and requests garbage row insertion.
module garbage_manager
    import garbage_manager_pkg::*;
#(
    parameter int CNT_WIDTH   = GARBAGE_CNT_WIDTH,
    parameter int MAX_PEND    = MAX_PENDING,
    parameter int MAX_INS     = MAX_INSERT,
    parameter int TX_MAX_BEAT = TX_MAX
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      game_start,
    input  logic                      send_valid,
    input  logic [CNT_WIDTH-1:0]      send_count,
    input  logic                      falling_piece_lock,
    input  logic                      lock_cleared,
    input  logic                      rx_valid,
    input  logic [LINE_CNT_WIDTH-1:0] rx_count,
    output logic                      tx_valid,
    output logic [LINE_CNT_WIDTH-1:0] tx_count,
    input  logic                      tx_ready,
    output logic                      insert_req,
    output logic [LINE_CNT_WIDTH-1:0] insert_count,
    output logic [HOLE_COL_WIDTH-1:0] insert_hole_col,
    input  logic                      insert_ack,
    output logic [CNT_WIDTH-1:0]      pending_garbage,
    output logic [CNT_WIDTH-1:0]      lines_tx_total
);

    localparam int W = CNT_WIDTH;
    localparam int L = LINE_CNT_WIDTH;

    localparam logic [W-1:0] ZERO_W     = {W{1'b0}};
    localparam logic [W-1:0] ONES_W     = {W{1'b1}};
    localparam logic [W:0]   ZERO_X     = {(W+1){1'b0}};
    localparam logic [W:0]   MAX_PEND_X = (W+1)'(MAX_PEND);
    localparam logic [W-1:0] MAX_PEND_W = W'(MAX_PEND);
    localparam logic [W-1:0] MAX_INS_W  = W'(MAX_INS);
    localparam logic [W-1:0] TX_MAX_W   = W'(TX_MAX_BEAT);
    localparam logic [L-1:0] MAX_INS_L  = L'(MAX_INS);
    localparam logic [L-1:0] TX_MAX_L   = L'(TX_MAX_BEAT);
    localparam logic [L-1:0] ZERO_L     = {L{1'b0}};

    tx_state_t                 tx_state_r;
    ins_state_t                ins_state_r;
    logic                      tx_valid_r;
    logic [L-1:0]              tx_count_r;
    logic                      insert_req_r;
    logic [L-1:0]              insert_count_r;
    logic [HOLE_COL_WIDTH-1:0] hole_col_r;
    logic [HOLE_COL_WIDTH-1:0] lfsr_col_s;

    logic [W-1:0] pend_r;
    logic [W-1:0] acc_r;
    logic [W-1:0] total_r;

    logic         ack_s;
    logic         hs_s;
    logic [W-1:0] p1_s;
    logic [W-1:0] cancel_s;
    logic [W-1:0] fresh_s;
    logic [W-1:0] a_dec_s;
    logic [W:0]   p_sum_s;
    logic [W:0]   a_sum_s;
    logic [W:0]   t_sum_s;
    logic [W-1:0] pend_nxt_s;
    logic [W-1:0] acc_nxt_s;
    logic [W-1:0] total_nxt_s;

    garbage_hole_lfsr u_hole_lfsr (
        .clk      (clk),
        .rst_l    (rst_l),
        .hole_col (lfsr_col_s)
    );

    // Pending/outgoing arithmetic: insertion retire, then cancel, then receive.
    always_comb begin
        ack_s = (ins_state_r == INS_REQ) && insert_ack;
        hs_s  = (tx_state_r == TX_SEND) && tx_ready;

        if (ack_s) begin
            if (pend_r > W'(insert_count_r)) begin
                p1_s = pend_r - W'(insert_count_r);
            end else begin
                p1_s = ZERO_W;
            end
        end else begin
            p1_s = pend_r;
        end

        if (send_valid) begin
            if (send_count < p1_s) begin
                cancel_s = send_count;
            end else begin
                cancel_s = p1_s;
            end
            fresh_s = send_count - cancel_s;
        end else begin
            cancel_s = ZERO_W;
            fresh_s  = ZERO_W;
        end

        p_sum_s    = {1'b0, p1_s - cancel_s} + (rx_valid ? (W+1)'(rx_count) : ZERO_X);
        pend_nxt_s = (p_sum_s > MAX_PEND_X) ? MAX_PEND_W : p_sum_s[W-1:0];

        // A beat never exceeds the accumulator it was latched from, so no underflow.
        a_dec_s   = hs_s ? (acc_r - W'(tx_count_r)) : acc_r;
        a_sum_s   = {1'b0, a_dec_s} + {1'b0, fresh_s};
        acc_nxt_s = a_sum_s[W] ? ONES_W : a_sum_s[W-1:0];

        t_sum_s     = {1'b0, total_r} + (W+1)'(tx_count_r);
        total_nxt_s = t_sum_s[W] ? ONES_W : t_sum_s[W-1:0];
    end

    // Pending and outgoing line accumulators.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pend_r <= ZERO_W;
            acc_r  <= ZERO_W;
        end else if (game_start) begin
            pend_r <= ZERO_W;
            acc_r  <= ZERO_W;
        end else begin
            pend_r <= pend_nxt_s;
            acc_r  <= acc_nxt_s;
        end
    end

    // Transmit FSM: one beat at a time, held stable until accepted.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tx_state_r <= TX_IDLE;
            tx_valid_r <= 1'b0;
            tx_count_r <= ZERO_L;
            total_r    <= ZERO_W;
        end else if (game_start) begin
            tx_state_r <= TX_IDLE;
            tx_valid_r <= 1'b0;
            tx_count_r <= ZERO_L;
            total_r    <= ZERO_W;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (acc_r != ZERO_W) begin
                        tx_count_r <= (acc_r > TX_MAX_W) ? TX_MAX_L : acc_r[L-1:0];
                        tx_valid_r <= 1'b1;
                        tx_state_r <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_ready) begin
                        total_r    <= total_nxt_s;
                        tx_valid_r <= 1'b0;
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Insert FSM: a non-clearing lock with garbage pending requests rows.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ins_state_r    <= INS_IDLE;
            insert_req_r   <= 1'b0;
            insert_count_r <= ZERO_L;
            hole_col_r     <= {HOLE_COL_WIDTH{1'b0}};
        end else if (game_start) begin
            ins_state_r    <= INS_IDLE;
            insert_req_r   <= 1'b0;
            insert_count_r <= ZERO_L;
            hole_col_r     <= {HOLE_COL_WIDTH{1'b0}};
        end else begin
            case (ins_state_r)
                INS_IDLE: begin
                    if (falling_piece_lock && !lock_cleared && (pend_r != ZERO_W)) begin
                        insert_count_r <= (pend_r > MAX_INS_W) ? MAX_INS_L : pend_r[L-1:0];
                        hole_col_r     <= lfsr_col_s;
                        insert_req_r   <= 1'b1;
                        ins_state_r    <= INS_REQ;
                    end
                end
                INS_REQ: begin
                    if (insert_ack) begin
                        insert_req_r <= 1'b0;
                        ins_state_r  <= INS_IDLE;
                    end
                end
                default: begin
                    insert_req_r <= 1'b0;
                    ins_state_r  <= INS_IDLE;
                end
            endcase
        end
    end

    assign tx_valid        = tx_valid_r;
    assign tx_count        = tx_count_r;
    assign insert_req      = insert_req_r;
    assign insert_count    = insert_count_r;
    assign insert_hole_col = hole_col_r;
    assign pending_garbage = pend_r;
    assign lines_tx_total  = total_r;

endmodule

// File: tb/tb_garbage_manager.sv
// Self-checking bench for garbage_manager: directed scenarios plus a random
// run against a line-count reference model.
module tb_garbage_manager;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       game_start;
    logic       send_valid;
    logic [9:0] send_count;
    logic       falling_piece_lock;
    logic       lock_cleared;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       tx_valid;
    logic [4:0] tx_count;
    logic       tx_ready;
    logic       insert_req;
    logic [4:0] insert_count;
    logic [3:0] insert_hole_col;
    logic       insert_ack;
    logic [9:0] pending_garbage;
    logic [9:0] lines_tx_total;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain line counts and "beat/insert outstanding" flags.
    int m_p, m_a, m_total, m_txc, m_insc;
    bit m_txv, m_ins;

    garbage_manager dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .game_start         (game_start),
        .send_valid         (send_valid),
        .send_count         (send_count),
        .falling_piece_lock (falling_piece_lock),
        .lock_cleared       (lock_cleared),
        .rx_valid           (rx_valid),
        .rx_count           (rx_count),
        .tx_valid           (tx_valid),
        .tx_count           (tx_count),
        .tx_ready           (tx_ready),
        .insert_req         (insert_req),
        .insert_count       (insert_count),
        .insert_hole_col    (insert_hole_col),
        .insert_ack         (insert_ack),
        .pending_garbage    (pending_garbage),
        .lines_tx_total     (lines_tx_total)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_p = 0; m_a = 0; m_total = 0; m_txc = 0; m_insc = 0;
        m_txv = 1'b0; m_ins = 1'b0;
    endtask

    task automatic clear_pulses();
        game_start = 1'b0; send_valid = 1'b0; send_count = 10'd0;
        falling_piece_lock = 1'b0; lock_cleared = 1'b0;
        rx_valid = 1'b0; rx_count = 5'd0; insert_ack = 1'b0;
    endtask

    // One clock: update the model from the inputs seen at the edge, then settle.
    task automatic cycle();
        int  p1, cancel, a_new;
        bit  hs, ack;
        @(posedge clk);
        if (game_start) begin
            model_reset();
        end else begin
            hs  = m_txv && tx_ready;
            ack = m_ins && insert_ack;
            p1  = m_p;
            if (ack) p1 = (m_p > m_insc) ? m_p - m_insc : 0;
            cancel = 0;
            if (send_valid) cancel = (int'(send_count) < p1) ? int'(send_count) : p1;
            a_new = m_a - (hs ? m_txc : 0) + (send_valid ? int'(send_count) - cancel : 0);
            if (a_new > 1023) a_new = 1023;
            if (hs) begin
                m_total = (m_total + m_txc > 1023) ? 1023 : m_total + m_txc;
                m_txv   = 1'b0;
            end else if (!m_txv && m_a != 0) begin
                m_txv = 1'b1;
                m_txc = (m_a < 31) ? m_a : 31;
            end
            if (ack) begin
                m_ins = 1'b0;
            end else if (!m_ins && falling_piece_lock && !lock_cleared && m_p != 0) begin
                m_ins  = 1'b1;
                m_insc = (m_p < 8) ? m_p : 8;
            end
            m_p = p1 - cancel + (rx_valid ? int'(rx_count) : 0);
            if (m_p > 20) m_p = 20;
            m_a = a_new;
        end
        #1;
        clear_pulses();
    endtask

    task automatic do_clear();
        tx_ready   = 1'b0;
        game_start = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({tx_valid, tx_count, insert_req, insert_count, insert_hole_col} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {tx_valid, tx_count, insert_req, insert_count, insert_hole_col});
        end
        n_checks++;
        if ({pending_garbage, lines_tx_total} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %h expected 0", {pending_garbage, lines_tx_total});
        end
        cycle();
        n_checks++;
        if (tx_valid !== 1'b0 || insert_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got tx_valid=%b insert_req=%b expected 0 0", tx_valid, insert_req);
        end
    endtask

    task automatic test_full_cancel();
        do_clear();
        rx_valid = 1'b1; rx_count = 5'd5;
        cycle();
        send_valid = 1'b1; send_count = 10'd3;
        cycle();
        n_checks++;
        if (pending_garbage !== 10'd2) begin
            n_fail++;
            $display("FAIL full_cancel_pending: got %0d expected 2", pending_garbage);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (tx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL full_cancel_no_tx: got tx_valid=%b expected 0 (cycle %0d)", tx_valid, i);
            end
        end
    endtask

    task automatic test_partial_cancel();
        send_valid = 1'b1; send_count = 10'd6;
        cycle();
        n_checks++;
        if (pending_garbage !== 10'd0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_cancel_pending: got pend=%0d tx_valid=%b expected 0 0",
                     pending_garbage, tx_valid);
        end
        cycle();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_count !== 5'd4) begin
            n_fail++;
            $display("FAIL partial_cancel_beat: got valid=%b count=%0d expected 1 4", tx_valid, tx_count);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (tx_valid !== 1'b1 || tx_count !== 5'd4) begin
                n_fail++;
                $display("FAIL backpressure_hold: got valid=%b count=%0d expected 1 4", tx_valid, tx_count);
            end
        end
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || lines_tx_total !== 10'd4) begin
            n_fail++;
            $display("FAIL handshake_total: got valid=%b total=%0d expected 0 4", tx_valid, lines_tx_total);
        end
        cycle();
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_extra_beat: got tx_valid=%b expected 0", tx_valid);
        end
    endtask

    task automatic test_capped_insert();
        do_clear();
        rx_valid = 1'b1; rx_count = 5'd12;
        cycle();
        falling_piece_lock = 1'b1;
        cycle();
        n_checks++;
        if (insert_req !== 1'b1 || insert_count !== 5'd8 || insert_hole_col > 4'd9) begin
            n_fail++;
            $display("FAIL capped_insert_req: got req=%b count=%0d col=%0d expected 1 8 <=9",
                     insert_req, insert_count, insert_hole_col);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (insert_req !== 1'b1 || pending_garbage !== 10'd12) begin
                n_fail++;
                $display("FAIL insert_hold: got req=%b pend=%0d expected 1 12", insert_req, pending_garbage);
            end
        end
        insert_ack = 1'b1;
        cycle();
        n_checks++;
        if (insert_req !== 1'b0 || pending_garbage !== 10'd4) begin
            n_fail++;
            $display("FAIL insert_ack: got req=%b pend=%0d expected 0 4", insert_req, pending_garbage);
        end
        falling_piece_lock = 1'b1; lock_cleared = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (insert_req !== 1'b0 || pending_garbage !== 10'd4) begin
            n_fail++;
            $display("FAIL clearing_lock: got req=%b pend=%0d expected 0 4", insert_req, pending_garbage);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'b1; rx_count = 5'd15;
            cycle();
        end
        n_checks++;
        if (pending_garbage !== 10'd20) begin
            n_fail++;
            $display("FAIL pending_saturate: got %0d expected 20", pending_garbage);
        end
        do_clear();
        rx_valid = 1'b1; rx_count = 5'd10;
        cycle();
        rx_valid = 1'b1; rx_count = 5'd5; send_valid = 1'b1; send_count = 10'd3;
        cycle();
        n_checks++;
        if (pending_garbage !== 10'd12) begin
            n_fail++;
            $display("FAIL rx_and_send: got %0d expected 12", pending_garbage);
        end
        repeat (2) cycle();
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_and_send_no_tx: got tx_valid=%b expected 0", tx_valid);
        end
    endtask

    task automatic test_game_start();
        do_clear();
        send_valid = 1'b1; send_count = 10'd40;
        cycle();
        cycle();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_count !== 5'd31) begin
            n_fail++;
            $display("FAIL gs_setup_beat: got valid=%b count=%0d expected 1 31", tx_valid, tx_count);
        end
        rx_valid = 1'b1; rx_count = 5'd10;
        cycle();
        falling_piece_lock = 1'b1;
        cycle();
        n_checks++;
        if (insert_req !== 1'b1) begin
            n_fail++;
            $display("FAIL gs_setup_insert: got insert_req=%b expected 1", insert_req);
        end
        game_start = 1'b1; rx_valid = 1'b1; rx_count = 5'd5;
        send_valid = 1'b1; send_count = 10'd9; falling_piece_lock = 1'b1;
        insert_ack = 1'b1; tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        n_checks++;
        if ({tx_valid, tx_count, insert_req, insert_count, insert_hole_col,
             pending_garbage, lines_tx_total} !== 36'd0) begin
            n_fail++;
            $display("FAIL gs_clear: got v=%b c=%0d r=%b ic=%0d col=%0d p=%0d t=%0d expected all 0",
                     tx_valid, tx_count, insert_req, insert_count, insert_hole_col,
                     pending_garbage, lines_tx_total);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (tx_valid !== 1'b0 || insert_req !== 1'b0 || pending_garbage !== 10'd0) begin
                n_fail++;
                $display("FAIL gs_no_stale: got v=%b r=%b p=%0d expected 0 0 0",
                         tx_valid, insert_req, pending_garbage);
            end
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        send_valid = 1'b1; send_count = 10'd7;
        cycle();
        cycle();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_count !== 5'd7) begin
            n_fail++;
            $display("FAIL ar_setup: got valid=%b count=%0d expected 1 7", tx_valid, tx_count);
        end
        #2;
        rst_l = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_count !== 5'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: got valid=%b count=%0d expected 0 0", tx_valid, tx_count);
        end
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (tx_valid !== 1'b0 || lines_tx_total !== 10'd0) begin
                n_fail++;
                $display("FAIL ar_idle: got valid=%b total=%0d expected 0 0", tx_valid, lines_tx_total);
            end
        end
        send_valid = 1'b1; send_count = 10'd3;
        cycle();
        cycle();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_count !== 5'd3) begin
            n_fail++;
            $display("FAIL ar_resume: got valid=%b count=%0d expected 1 3", tx_valid, tx_count);
        end
    endtask

    task automatic test_lfsr_sweep();
        bit seen [16];
        int distinct;
        for (int c = 0; c < 16; c++) seen[c] = 1'b0;
        do_clear();
        for (int k = 0; k < 90; k++) begin
            rx_valid = 1'b1; rx_count = 5'd1;
            cycle();
            falling_piece_lock = 1'b1;
            cycle();
            n_checks++;
            if (insert_req !== 1'b1 || insert_count !== 5'd1 || insert_hole_col > 4'd9) begin
                n_fail++;
                $display("FAIL lfsr_col: got req=%b count=%0d col=%0d expected 1 1 <=9",
                         insert_req, insert_count, insert_hole_col);
            end
            seen[insert_hole_col] = 1'b1;
            insert_ack = 1'b1;
            cycle();
            repeat ($urandom_range(0, 8)) cycle();
        end
        distinct = 0;
        for (int c = 0; c < 16; c++) if (seen[c]) distinct++;
        n_checks++;
        if (distinct < 6) begin
            n_fail++;
            $display("FAIL lfsr_spread: got %0d distinct columns expected >=6", distinct);
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 2000; i++) begin
            game_start         = ($urandom_range(0, 199) == 0);
            rx_valid           = ($urandom_range(0, 5) == 0);
            rx_count           = 5'($urandom_range(0, 31));
            send_valid         = ($urandom_range(0, 4) == 0);
            send_count         = 10'($urandom_range(0, 45));
            falling_piece_lock = ($urandom_range(0, 7) == 0);
            lock_cleared       = 1'($urandom_range(0, 1));
            insert_ack         = ($urandom_range(0, 2) == 0);
            tx_ready           = 1'($urandom_range(0, 1));
            cycle();
            n_checks++;
            if (pending_garbage !== 10'(m_p) || lines_tx_total !== 10'(m_total)) begin
                n_fail++;
                $display("FAIL rand_counts @%0d: got p=%0d t=%0d expected p=%0d t=%0d",
                         i, pending_garbage, lines_tx_total, m_p, m_total);
            end
            n_checks++;
            if (tx_valid !== m_txv || tx_count !== 5'(m_txc)) begin
                n_fail++;
                $display("FAIL rand_tx @%0d: got v=%b c=%0d expected v=%b c=%0d",
                         i, tx_valid, tx_count, m_txv, m_txc);
            end
            n_checks++;
            if (insert_req !== m_ins || insert_count !== 5'(m_insc)) begin
                n_fail++;
                $display("FAIL rand_insert @%0d: got r=%b c=%0d expected r=%b c=%0d",
                         i, insert_req, insert_count, m_ins, m_insc);
            end
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        rst_l    = 1'b0;
        tx_ready = 1'b0;
        clear_pulses();
        model_reset();
        #12;
        rst_l = 1'b1;
        test_reset();
        test_full_cancel();
        test_partial_cancel();
        test_capped_insert();
        test_saturation();
        test_game_start();
        test_async_reset();
        test_lfsr_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
